// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the serial program loader.
// Widths match the 4 KiB x 8 instruction RAM write port.
package prog_loader_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 9;

    localparam logic [DATA_W-1:0] SYNC_BYTE_DEF = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR_HI,
        ST_ADDR_LO,
        ST_LEN,
        ST_DATA,
        ST_CSUM
    } state_t;

    // A LEN byte of zero encodes a full 256-byte payload.
    function automatic logic [CNT_W-1:0] len_to_count(input logic [DATA_W-1:0] len);
        return (len == '0) ? CNT_W'(256) : CNT_W'(len);
    endfunction

endpackage

// File: rtl/prog_loader_timeout.sv
// Purpose: inter-byte idle watchdog for the loader frame parser.
// Latency: o_expired is combinational from the count; fires TIMEOUT_CYCLES-1 idle cycles after the last clear.
// Backpressure: none; i_clear always wins over expiry in the same cycle.
module prog_loader_timeout #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_cnt;
    logic          w_at_last;

    assign w_at_last = (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear || !i_enable) begin
            r_cnt <= '0;
        end else if (!w_at_last) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_expired = i_enable && !i_clear && w_at_last;

endmodule

// File: rtl/prog_loader.sv
// Purpose: parse SYNC/ADDR_HI/ADDR_LO/LEN/data/CSUM frames from the UART and write the instruction RAM.
// Latency: RAM write, done, err and cpu_rst_n all register one cycle after the rx_valid that caused them.
// Backpressure: none; every rx_valid strobe is consumed in its own cycle, back-to-back included.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
    parameter int         TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [11:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        cpu_rst_n,
    output logic        busy,
    output logic        done,
    output logic        err
);

    state_t              r_state;
    state_t              w_state_nxt;

    logic [ADDR_W-1:0]   r_addr;
    logic [CNT_W-1:0]    r_remain;
    logic [DATA_W-1:0]   r_sum;

    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_mem_we;
    logic                r_cpu_rst_n;
    logic                r_done;
    logic                r_err;

    logic                w_start;
    logic                w_wr;
    logic                w_pass;
    logic                w_fail;
    logic                w_sum_en;
    logic                w_expired;
    logic                w_in_frame;

    assign w_in_frame = (r_state != ST_IDLE);

    prog_loader_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (rx_valid),
        .i_enable  (w_in_frame),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_wr        = 1'b0;
        w_pass      = 1'b0;
        w_fail      = 1'b0;
        w_sum_en    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (rx_valid && (rx_data == SYNC_BYTE)) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_ADDR_HI;
                end
            end
            ST_ADDR_HI: begin
                if (rx_valid) begin
                    if (rx_data[7:4] != 4'h0) begin
                        w_fail      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_sum_en    = 1'b1;
                        w_state_nxt = ST_ADDR_LO;
                    end
                end
            end
            ST_ADDR_LO: begin
                if (rx_valid) begin
                    w_sum_en    = 1'b1;
                    w_state_nxt = ST_LEN;
                end
            end
            ST_LEN: begin
                if (rx_valid) begin
                    w_sum_en    = 1'b1;
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                // Sync-valued bytes here are payload, not a new frame.
                if (rx_valid) begin
                    w_wr     = 1'b1;
                    w_sum_en = 1'b1;
                    if (r_remain == CNT_W'(1)) begin
                        w_state_nxt = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (rx_valid) begin
                    w_state_nxt = ST_IDLE;
                    if (rx_data == r_sum) begin
                        w_pass = 1'b1;
                    end else begin
                        w_fail = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Expiry cannot coincide with rx_valid, so it never masks an accepted byte.
        if (w_expired) begin
            w_state_nxt = ST_IDLE;
            w_fail      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr   <= '0;
            r_remain <= '0;
            r_sum    <= '0;
        end else begin
            if (w_start) begin
                r_sum <= '0;
            end else if (w_sum_en) begin
                r_sum <= r_sum + rx_data;
            end

            if (rx_valid) begin
                case (r_state)
                    ST_ADDR_HI: r_addr[11:8] <= rx_data[3:0];
                    ST_ADDR_LO: r_addr[7:0]  <= rx_data;
                    ST_LEN:     r_remain     <= len_to_count(rx_data);
                    ST_DATA: begin
                        r_addr   <= r_addr + ADDR_W'(1);
                        r_remain <= r_remain - CNT_W'(1);
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
            r_cpu_rst_n <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_mem_we <= w_wr;
            r_done   <= w_pass;

            if (w_wr) begin
                r_mem_addr  <= r_addr;
                r_mem_wdata <= rx_data;
            end

            // The CPU is only released by a verified frame; any abort leaves it held.
            if (w_start) begin
                r_err       <= 1'b0;
                r_cpu_rst_n <= 1'b0;
            end else if (w_fail) begin
                r_err       <= 1'b1;
            end else if (w_pass) begin
                r_cpu_rst_n <= 1'b1;
            end
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_we    = r_mem_we;
    assign cpu_rst_n = r_cpu_rst_n;
    assign busy      = w_in_frame;
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected RAM writes are queued as bytes are sent
// and popped by a monitor whenever mem_we is observed.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        cpu_rst_n;
    logic        busy;
    logic        done;
    logic        err;

    int errors   = 0;
    int checks   = 0;
    int done_cnt = 0;

    typedef struct packed {
        logic [11:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        mon_w;
    logic [7:0] payload [256];

    prog_loader #(
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .cpu_rst_n (cpu_rst_n),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (mem_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%h data=%h, expected no write", mem_addr, mem_wdata);
            end else begin
                mon_w = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== {mon_w.a, mon_w.d}) begin
                    errors++;
                    $display("FAIL write_data: got addr=%h data=%h, expected addr=%h data=%h",
                             mem_addr, mem_wdata, mon_w.a, mon_w.d);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [7:0] frame_sum(input logic [7:0] ahi, input logic [7:0] alo, input int n);
        logic [7:0] s;
        logic [7:0] len_b;
        len_b = n[7:0];
        s = ahi + alo + len_b;
        for (int i = 0; i < n; i++) s = s + payload[i];
        return s;
    endfunction

    task automatic send_frame(input logic [7:0] ahi, input logic [7:0] alo, input int n, input logic [7:0] csum);
        logic [11:0] a;
        logic [7:0]  len_b;
        a     = {ahi[3:0], alo};
        len_b = n[7:0];
        send_byte(8'hA5);
        checks++;
        if ({busy, err} !== 2'b10) begin
            errors++;
            $display("FAIL sync_accept: got busy=%b err=%b, expected busy=1 err=0", busy, err);
        end
        send_byte(ahi);
        send_byte(alo);
        send_byte(len_b);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{a: a + 12'(i), d: payload[i]});
            send_byte(payload[i]);
        end
        send_byte(csum);
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: got %0d writes still missing, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        idle(3);
        rst_n = 1'b1;
        idle(1);
        checks++;
        if ({mem_addr, mem_wdata, mem_we, cpu_rst_n, busy, done, err} !== 25'b0) begin
            errors++;
            $display("FAIL reset_values: got addr=%h wdata=%h we=%b cpu_rst_n=%b busy=%b done=%b err=%b, expected all 0",
                     mem_addr, mem_wdata, mem_we, cpu_rst_n, busy, done, err);
        end
        send_byte(8'h3C);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignore: got busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_good_frame;
        int d0;
        d0 = done_cnt;
        payload[0] = 8'hC0;
        payload[1] = 8'h04;
        payload[2] = 8'h70;
        send_frame(8'h00, 8'h10, 3, 8'h47);
        checks++;
        if ({done, cpu_rst_n, err, busy} !== 4'b1100) begin
            errors++;
            $display("FAIL good_frame_end: got done=%b cpu_rst_n=%b err=%b busy=%b, expected 1 1 0 0",
                     done, cpu_rst_n, err, busy);
        end
        idle(1);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse_width: got done=%b, expected 0", done);
        end
        idle(1);
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL good_frame_done_count: got %0d, expected 1", done_cnt - d0);
        end
        check_drained("good_frame_writes");
    endtask

    task automatic test_wrap;
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < 256; i++) payload[i] = 8'(i);
        send_frame(8'h0F, 8'h80, 256, frame_sum(8'h0F, 8'h80, 256));
        checks++;
        if ({done, err, cpu_rst_n} !== 3'b101) begin
            errors++;
            $display("FAIL wrap_end: got done=%b err=%b cpu_rst_n=%b, expected 1 0 1", done, err, cpu_rst_n);
        end
        idle(2);
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL wrap_done_count: got %0d, expected 1", done_cnt - d0);
        end
        check_drained("wrap_writes");
    endtask

    task automatic test_bad_csum;
        int d0;
        d0 = done_cnt;
        payload[0] = 8'hC0;
        payload[1] = 8'h04;
        payload[2] = 8'h70;
        send_frame(8'h00, 8'h10, 3, 8'h48);
        checks++;
        if ({err, cpu_rst_n, done, busy} !== 4'b1000) begin
            errors++;
            $display("FAIL bad_csum_end: got err=%b cpu_rst_n=%b done=%b busy=%b, expected 1 0 0 0",
                     err, cpu_rst_n, done, busy);
        end
        idle(2);
        checks++;
        if (done_cnt != d0) begin
            errors++;
            $display("FAIL bad_csum_done_count: got %0d, expected 0", done_cnt - d0);
        end
        check_drained("bad_csum_writes");
        send_frame(8'h00, 8'h10, 3, 8'h47);
        checks++;
        if ({err, cpu_rst_n} !== 2'b01) begin
            errors++;
            $display("FAIL recover_after_bad_csum: got err=%b cpu_rst_n=%b, expected 0 1", err, cpu_rst_n);
        end
        check_drained("recover_writes");
    endtask

    task automatic test_bad_addr_hi;
        send_byte(8'hA5);
        send_byte(8'h1F);
        checks++;
        if ({err, busy, cpu_rst_n} !== 3'b100) begin
            errors++;
            $display("FAIL bad_addr_hi: got err=%b busy=%b cpu_rst_n=%b, expected 1 0 0", err, busy, cpu_rst_n);
        end
        send_byte(8'h00);
        send_byte(8'h03);
        send_byte(8'hC0);
        send_byte(8'h04);
        send_byte(8'h70);
        idle(2);
        checks++;
        if ({err, busy} !== 2'b10) begin
            errors++;
            $display("FAIL bad_addr_hi_after: got err=%b busy=%b, expected 1 0", err, busy);
        end
    endtask

    task automatic test_timeout;
        send_byte(8'hA5);
        send_byte(8'h00);
        for (int k = 1; k <= 16; k++) begin
            idle(1);
            if (k == 15) begin
                checks++;
                if ({err, busy} !== 2'b01) begin
                    errors++;
                    $display("FAIL timeout_early: got err=%b busy=%b, expected 0 1", err, busy);
                end
            end
            if (k == 16) begin
                checks++;
                if ({err, busy, cpu_rst_n} !== 3'b100) begin
                    errors++;
                    $display("FAIL timeout_expire: got err=%b busy=%b cpu_rst_n=%b, expected 1 0 0",
                             err, busy, cpu_rst_n);
                end
            end
        end
    endtask

    task automatic test_timeout_race;
        send_byte(8'hA5);
        send_byte(8'h00);
        idle(15);
        send_byte(8'h10);
        checks++;
        if ({err, busy} !== 2'b01) begin
            errors++;
            $display("FAIL timeout_race: got err=%b busy=%b, expected 0 1", err, busy);
        end
        exp_q.push_back('{a: 12'h010, d: 8'h5A});
        send_byte(8'h01);
        send_byte(8'h5A);
        send_byte(8'h6B);
        checks++;
        if ({done, err, cpu_rst_n} !== 3'b101) begin
            errors++;
            $display("FAIL timeout_race_end: got done=%b err=%b cpu_rst_n=%b, expected 1 0 1", done, err, cpu_rst_n);
        end
        idle(1);
        check_drained("timeout_race_writes");
    endtask

    task automatic test_reset_mid_data;
        int d0;
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h10);
        send_byte(8'h03);
        exp_q.push_back('{a: 12'h010, d: 8'hC0});
        send_byte(8'hC0);
        d0 = done_cnt;
        rst_n = 1'b0;
        idle(1);
        checks++;
        if ({mem_addr, mem_wdata, mem_we, cpu_rst_n, busy, done, err} !== 25'b0) begin
            errors++;
            $display("FAIL reset_mid_data: got addr=%h wdata=%h we=%b cpu_rst_n=%b busy=%b done=%b err=%b, expected all 0",
                     mem_addr, mem_wdata, mem_we, cpu_rst_n, busy, done, err);
        end
        rst_n = 1'b1;
        send_byte(8'h04);
        send_byte(8'h70);
        send_byte(8'h47);
        idle(2);
        checks++;
        if ({cpu_rst_n, busy, err} !== 3'b000 || done_cnt != d0) begin
            errors++;
            $display("FAIL reset_mid_data_after: got cpu_rst_n=%b busy=%b err=%b done_pulses=%0d, expected 0 0 0 0",
                     cpu_rst_n, busy, err, done_cnt - d0);
        end
        check_drained("reset_mid_data_writes");
    endtask

    initial begin
        test_reset();
        checks++;
        if (cpu_rst_n !== 1'b0) begin
            errors++;
            $display("FAIL power_up_cpu_hold: got cpu_rst_n=%b, expected 0", cpu_rst_n);
        end
        test_good_frame();
        test_wrap();
        test_bad_csum();
        test_bad_addr_hi();
        test_timeout();
        test_timeout_race();
        test_reset_mid_data();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Serial program loader for the blinky SoC. Accepts a framed byte stream from the UART receiver and writes the payload into the 4 KiB instruction RAM, the write side of the 12-bit-address / 8-bit-data instruction memory that the CPU fetches from. The loader holds the CPU in reset while loading and releases it once a frame passes its checksum.

## Interface
- `SYNC_BYTE`, default 8'hA5: frame start marker.
- `TIMEOUT_CYCLES`, default 1_000_000: maximum idle cycles between bytes inside a frame.
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst_n`, input, 1: reset; synchronous, active-low.
- `rx_data`, input, 8: received byte; valid only while `rx_valid` is high.
- `rx_valid`, input, 1: one-cycle strobe per received byte; no back-pressure.
- `mem_addr`, output, 12: instruction RAM write address.
- `mem_wdata`, output, 8: instruction RAM write data.
- `mem_we`, output, 1: one-cycle write strobe.
- `cpu_rst_n`, output, 1: CPU reset, active-low.
- `busy`, output, 1: high while in any state other than IDLE.
- `done`, output, 1: one-cycle pulse on a good frame.
- `err`, output, 1: sticky error flag; cleared when the next sync byte is accepted.

## Operation
- Frame format: `SYNC_BYTE`, ADDR_HI, ADDR_LO, LEN, LEN data bytes, CSUM.
  - ADDR_HI[7:4] must be 0. ADDR_HI[3:0] supplies address bits 11:8.
  - LEN = 0 means 256 bytes.
- States: IDLE → ADDR_HI → ADDR_LO → LEN → DATA → CSUM → IDLE. Each transition is taken only on `rx_valid`.
- IDLE
  - Bytes other than `SYNC_BYTE` are ignored.
  - On `SYNC_BYTE`: clear `err`, drive `cpu_rst_n`=0, clear the running sum, go to ADDR_HI.
- ADDR_HI: if bits [7:4] ≠ 0, set `err` and return to IDLE (`cpu_rst_n` stays 0).
- Running sum: 8-bit sum, mod 256, of ADDR_HI, ADDR_LO, LEN and every data byte. `SYNC_BYTE` is excluded.
- DATA
  - Each byte is written to the current address, then the address increments.
  - The address wraps 12'hFFF → 12'h000.
  - A 9-bit remaining counter reaching 0 moves to CSUM.
  - `SYNC_BYTE` values inside DATA are treated as payload.
- CSUM
  - Match: pulse `done`, drive `cpu_rst_n`=1.
  - Mismatch: set `err`, keep `cpu_rst_n`=0.
  - Either way, go to IDLE. Bytes already written are not rolled back.
- Timeout
  - The counter runs in every non-IDLE state and clears on `rx_valid`.
  - Reaching TIMEOUT_CYCLES−1 without a byte: go to IDLE, set `err`, keep `cpu_rst_n`=0.
  - `rx_valid` in the expiry cycle wins: the byte is accepted and the counter cleared.

## Timing
- Reset values: `mem_addr`=0, `mem_wdata`=0, `mem_we`=0, `cpu_rst_n`=0, `busy`=0, `done`=0, `err`=0, state IDLE.
- The CPU stays in reset after power-up until the first good frame.
- Write latency: `mem_we`, `mem_addr` and `mem_wdata` are registered and valid in the cycle after the `rx_valid` that carried the data byte. `mem_we` is high for exactly one cycle.
- Completion: `done` and the `cpu_rst_n` rise occur in the cycle after the CSUM `rx_valid`.
- Errors: `err` rises in the cycle after the offending byte, or in the cycle after timeout expiry.
- `busy` goes high in the cycle after the accepted sync byte and low in the cycle after the frame ends or aborts.
- Back-to-back `rx_valid` on consecutive cycles must be handled with no loss.
- `rst_n` low mid-frame: in the next cycle all outputs return to their reset values and no further `mem_we` is issued.

## Structure
- Shared package `prog_loader_pkg`:
  - state enum (IDLE, ADDR_HI, ADDR_LO, LEN, DATA, CSUM)
  - `SYNC_BYTE` default
  - address and data width constants (12, 8)
- One sub-module, `prog_loader_timeout`:
  - inputs: clear, enable
  - output: expired pulse
  - parameterised by TIMEOUT_CYCLES, counter width $clog2(TIMEOUT_CYCLES).

## Test plan
- Good frame: A5 00 10 03 C0 04 70 CS=0x47.
  - Required: writes 0x010=C0, 0x011=04, 0x012=70.
  - `done` pulses once, `cpu_rst_n` goes 0→1, `err`=0.
- Wrap with LEN=0 (256 bytes): A5 0F 80 00, data 0x00..0xFF, correct CSUM.
  - Required: writes cover 0xF80..0xFFF, then 0x000..0x07F, with data matching.
  - `done` pulses once.
- Bad checksum: same frame as the good-frame case with CS=0x48.
  - Required: all 3 writes occur, `err`=1, `done` never pulses, `cpu_rst_n` stays 0.
  - A following good frame clears `err` and raises `cpu_rst_n`.
- Bad ADDR_HI: A5 1F …
  - Required: `err`=1, return to IDLE.
  - Following data bytes, including non-A5 bytes, produce no `mem_we`.
- Timeout with TIMEOUT_CYCLES=16: A5 00 then silence.
  - Required: `err` rises 16 cycles after the 00 byte, and `busy` falls.
  - A byte at exactly the expiry cycle is accepted instead.
- Reset mid-DATA: assert `rst_n`=0 after 1 of 3 data bytes.
  - Required: all outputs return to reset values next cycle, and the remaining bytes produce no writes.
